// File: rtl/ntt_sram_port_ctrl.sv
// ntt_sram_port_ctrl: single-port controller that fills the 128x16 coefficient SRAM from a stream and drains it in natural or bit-reversed order
// Ports: clk/rst_n; start_load, start_drain, bitrev commands; in_valid/in_data/in_ready load stream;
//        out_valid/out_data/out_ready drain stream; busy, done status; sram_* registered macro pins, sram_o read data.
module ntt_sram_port_ctrl #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 1 << ADDR_W,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_load,
  input  logic              start_drain,
  input  logic              bitrev,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  input  logic [DATA_W-1:0] sram_o
);
  localparam int PW = $clog2(OFIFO_DEPTH);
  localparam int CW = $clog2(OFIFO_DEPTH + 3);
  typedef enum logic [1:0] {IDLE, LOAD, LFIN, DRAIN} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] wcnt_q, popcnt_q, rev_addr, rd_addr;
  logic [ADDR_W:0]   rcnt_q;
  logic              bitrev_q, in_ready_q, done_q, rd_p1_q, rd_p2_q;
  logic [ADDR_W-1:0] sram_a_q;
  logic [DATA_W-1:0] sram_i_q;
  logic              sram_csb_q, sram_web_q, sram_oeb_q;
  logic [DATA_W-1:0] mem_q [OFIFO_DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     cnt_q;
  logic              hs, issue, push, pop, last_pop;
  for (genvar g = 0; g < ADDR_W; g++) begin : g_rev
    assign rev_addr[g] = rcnt_q[ADDR_W-1-g];
  end
  assign rd_addr   = bitrev_q ? rev_addr : rcnt_q[ADDR_W-1:0];
  assign hs        = state_q == LOAD && in_valid && in_ready_q;
  // Credit check counts FIFO entries plus reads still in the 2-cycle macro pipeline.
  assign issue     = state_q == DRAIN && rcnt_q < (ADDR_W+1)'(DEPTH) &&
                     (cnt_q + CW'(rd_p1_q) + CW'(rd_p2_q)) < CW'(OFIFO_DEPTH);
  assign push      = rd_p2_q;
  assign pop       = out_valid && out_ready;
  assign last_pop  = state_q == DRAIN && pop && popcnt_q == ADDR_W'(DEPTH - 1);
  assign in_ready  = in_ready_q;
  assign out_valid = |cnt_q;
  assign out_data  = mem_q[rp_q];
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign sram_a    = sram_a_q;
  assign sram_i    = sram_i_q;
  assign sram_csb  = sram_csb_q;
  assign sram_web  = sram_web_q;
  assign sram_oeb  = sram_oeb_q;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(OFIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      popcnt_q   <= '0;
      bitrev_q   <= 1'b0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      rd_p1_q    <= 1'b0;
      rd_p2_q    <= 1'b0;
      sram_a_q   <= '0;
      sram_i_q   <= '0;
      sram_csb_q <= 1'b1;
      sram_web_q <= 1'b1;
      sram_oeb_q <= 1'b1;
    end else begin
      done_q  <= 1'b0;
      rd_p1_q <= issue;
      rd_p2_q <= rd_p1_q;
      case (state_q)
        IDLE: begin
          sram_csb_q <= 1'b1;
          sram_web_q <= 1'b1;
          sram_oeb_q <= 1'b1;
          if (start_load) begin
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
            wcnt_q     <= '0;
          end else if (start_drain) begin
            state_q    <= DRAIN;
            sram_oeb_q <= 1'b0;
            bitrev_q   <= bitrev;
            rcnt_q     <= '0;
            popcnt_q   <= '0;
          end
        end
        LOAD: begin
          sram_csb_q <= !hs;
          sram_web_q <= !hs;
          if (hs) begin
            sram_a_q <= wcnt_q;
            sram_i_q <= in_data;
            wcnt_q   <= wcnt_q + 1'b1;
            if (wcnt_q == ADDR_W'(DEPTH - 1)) begin
              in_ready_q <= 1'b0;
              state_q    <= LFIN;
            end
          end
        end
        LFIN: begin
          sram_csb_q <= 1'b1;
          sram_web_q <= 1'b1;
          state_q    <= IDLE;
          done_q     <= 1'b1;
        end
        DRAIN: begin
          sram_web_q <= 1'b1;
          sram_csb_q <= !issue;
          if (issue) begin
            sram_a_q <= rd_addr;
            rcnt_q   <= rcnt_q + 1'b1;
          end
          if (pop) popcnt_q <= popcnt_q + 1'b1;
          if (last_pop) begin
            state_q    <= IDLE;
            done_q     <= 1'b1;
            sram_oeb_q <= 1'b1;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int j = 0; j < OFIFO_DEPTH; j++) mem_q[j] <= '0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= sram_o;
        wp_q        <= inc(wp_q);
      end
      if (pop) rp_q <= inc(rp_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
endmodule
